// File: rtl/me_pkg.sv
// me_pkg: definitions shared by the memory loader and its write stage.
// Holds the loader state encoding and the memory geometry constants.
package me_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_TB = 2'd1,
    LOAD_SW = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

  localparam int TB_DEPTH = 64;
  localparam int SW_DEPTH = 1024;
  localparam int PIX_W    = 8;

endpackage

// File: rtl/me_wr_port.sv
// me_wr_port: one registered write stage (we/addr/data) for a memory port.
// A request on wr_en in cycle N appears on we/waddr/wdata in cycle N+1.
// rst resets the stage and drops any request that is in flight.
// Ports:
//   clk, rst          clock, synchronous active-high reset/flush
//   wr_en, addr, data write request captured this cycle
//   we, waddr, wdata  registered write toward the memory
module me_wr_port #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata
);

  logic          we_r;
  logic [AW-1:0] waddr_r;
  logic [DW-1:0] wdata_r;

  // Pipeline register; address/data only move on a request so they hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= '0;
    end else begin
      we_r <= wr_en;
      if (wr_en) begin
        waddr_r <= addr;
        wdata_r <= data;
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  assign we    = we_r;
  assign waddr = waddr_r;
  assign wdata = wdata_r;

endmodule

// File: rtl/me_mem_loader.sv
// me_mem_loader: writes a raster pixel stream into the template memory
// (first 2**TB_AW pixels) and then the search-window memory (next 2**SW_AW
// pixels), pulsing done in the cycle of the last search-window write.
// Optional feature macro: ME_MEM_LOADER_CHECKSUM_EN adds a running checksum.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, abort             begin a load (IDLE only) / return to IDLE
//   pix_valid, pix_data      input pixel stream; pix_ready accepts it
//   tb_we/tb_waddr/tb_wdata  template memory write port (1-cycle latency)
//   sw_we/sw_waddr/sw_wdata  search-window memory write port (1-cycle latency)
//   busy, done               loading / one-cycle completion pulse
//   checksum                 (macro only) sum of accepted pixels since start
module me_mem_loader #(
  parameter int PIX_W = me_pkg::PIX_W,
  parameter int TB_AW = $clog2(me_pkg::TB_DEPTH),
  parameter int SW_AW = $clog2(me_pkg::SW_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             tb_we,
  output logic [TB_AW-1:0] tb_waddr,
  output logic [PIX_W-1:0] tb_wdata,
  output logic             sw_we,
  output logic [SW_AW-1:0] sw_waddr,
  output logic [PIX_W-1:0] sw_wdata,
  output logic             busy,
  output logic             done
`ifdef ME_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [PIX_W+SW_AW:0] checksum
`endif
);

  import me_pkg::*;

  localparam logic [TB_AW-1:0] TB_LAST = '1;
  localparam logic [SW_AW-1:0] SW_LAST = '1;

  loader_state_t    state_r;
  loader_state_t    state_next_s;
  logic [TB_AW-1:0] tb_cnt_r;
  logic [SW_AW-1:0] sw_cnt_r;
  logic             pix_ready_s;
  logic             busy_s;
  logic             done_s;
  logic             beat_s;
  logic             start_ok_s;
  logic             tb_wr_s;
  logic             sw_wr_s;

  // A coincident abort does not drop ready: that beat is still written.
  assign beat_s     = pix_valid & pix_ready_s;
  assign start_ok_s = (state_r == IDLE) & start & ~abort;
  assign tb_wr_s    = beat_s & (state_r == LOAD_TB);
  assign sw_wr_s    = beat_s & (state_r == LOAD_SW);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; abort dominates start and beats.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_next_s = LOAD_TB;
        else            state_next_s = IDLE;
      end
      LOAD_TB: begin
        if (abort)                              state_next_s = IDLE;
        else if (beat_s && tb_cnt_r == TB_LAST) state_next_s = LOAD_SW;
        else                                    state_next_s = LOAD_TB;
      end
      LOAD_SW: begin
        if (abort)                              state_next_s = IDLE;
        else if (beat_s && sw_cnt_r == SW_LAST) state_next_s = DONE;
        else                                    state_next_s = LOAD_SW;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State-decoded outputs; done coincides with the final registered sw write.
  always_comb begin
    pix_ready_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE:    begin pix_ready_s = 1'b0; busy_s = 1'b0; done_s = 1'b0; end
      LOAD_TB: begin pix_ready_s = 1'b1; busy_s = 1'b1; done_s = 1'b0; end
      LOAD_SW: begin pix_ready_s = 1'b1; busy_s = 1'b1; done_s = 1'b0; end
      DONE:    begin pix_ready_s = 1'b0; busy_s = 1'b0; done_s = 1'b1; end
      default: begin pix_ready_s = 1'b0; busy_s = 1'b0; done_s = 1'b0; end
    endcase
  end

  // Address counters: cleared on reset/abort/start, advance per beat of their phase.
  // Both wrap naturally to 0 at their last address, ready for the next load.
  always_ff @(posedge clk) begin
    if (rst || abort || start_ok_s) begin
      tb_cnt_r <= '0;
      sw_cnt_r <= '0;
    end else begin
      if (tb_wr_s) tb_cnt_r <= tb_cnt_r + 1'b1;
      else         tb_cnt_r <= tb_cnt_r;
      if (sw_wr_s) sw_cnt_r <= sw_cnt_r + 1'b1;
      else         sw_cnt_r <= sw_cnt_r;
    end
  end

  me_wr_port #(.AW(TB_AW), .DW(PIX_W)) u_tb_port (
    .clk   (clk),
    .rst   (rst),
    .wr_en (tb_wr_s),
    .addr  (tb_cnt_r),
    .data  (pix_data),
    .we    (tb_we),
    .waddr (tb_waddr),
    .wdata (tb_wdata)
  );

  me_wr_port #(.AW(SW_AW), .DW(PIX_W)) u_sw_port (
    .clk   (clk),
    .rst   (rst),
    .wr_en (sw_wr_s),
    .addr  (sw_cnt_r),
    .data  (pix_data),
    .we    (sw_we),
    .waddr (sw_waddr),
    .wdata (sw_wdata)
  );

  assign pix_ready = pix_ready_s;
  assign busy      = busy_s;
  assign done      = done_s;

`ifdef ME_MEM_LOADER_CHECKSUM_EN
  logic [PIX_W+SW_AW:0] checksum_r;

  // Running sum of accepted pixels; wide enough for a full load of max pixels.
  always_ff @(posedge clk) begin
    if (rst || abort || start_ok_s) begin
      checksum_r <= '0;
    end else if (beat_s) begin
      checksum_r <= checksum_r + {{(SW_AW+1){1'b0}}, pix_data};
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_me_mem_loader.sv
// Self-checking bench for me_mem_loader: a beat-index model predicts every
// output each cycle, plus literal checks on counts and boundary data.
module tb_me_mem_loader;

  localparam int TB_N  = 64;
  localparam int SW_N  = 1024;
  localparam int TOTAL = TB_N + SW_N;

  logic       clk = 1'b0;
  logic       rst, start, abort, pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready, tb_we, sw_we, busy, done;
  logic [5:0] tb_waddr;
  logic [7:0] tb_wdata, sw_wdata;
  logic [9:0] sw_waddr;
`ifdef ME_MEM_LOADER_CHECKSUM_EN
  logic [18:0] checksum;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // Model: a load is just "accept TOTAL beats; beat k writes tb[k] or sw[k-64]".
  bit         m_active, m_done, m_tb_we, m_sw_we;
  int         m_idx;
  logic [5:0] m_tb_addr;
  logic [7:0] m_tb_data, m_sw_data;
  logic [9:0] m_sw_addr;
  longint     m_sum;

  // Statistics gathered by the compare loop.
  int         done_cnt, tb_wr, sw_wr, tb63_cyc, sw0_cyc, last_sw_addr;
  logic [7:0] first_sw_data, last_sw_data;
  longint     sum_at_done;

  me_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .tb_we     (tb_we),
    .tb_waddr  (tb_waddr),
    .tb_wdata  (tb_wdata),
    .sw_we     (sw_we),
    .sw_waddr  (sw_waddr),
    .sw_wdata  (sw_wdata),
    .busy      (busy),
    .done      (done)
`ifdef ME_MEM_LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    int idx_v;
    bit beat_v;
    if (rst) begin
      m_active <= 1'b0; m_done <= 1'b0; m_tb_we <= 1'b0; m_sw_we <= 1'b0;
      m_idx <= 0; m_sum <= 0;
    end else begin
      beat_v = pix_valid && m_active;
      idx_v  = m_idx;
      m_tb_we <= beat_v && (m_idx < TB_N);
      m_sw_we <= beat_v && (m_idx >= TB_N);
      if (beat_v) begin
        if (m_idx < TB_N) begin
          m_tb_addr <= m_idx[5:0];
          m_tb_data <= pix_data;
        end else begin
          m_sw_addr <= 10'(m_idx - TB_N);
          m_sw_data <= pix_data;
        end
        idx_v = m_idx + 1;
      end
      m_done <= 1'b0;
      if (abort) begin
        m_active <= 1'b0; m_idx <= 0; m_sum <= 0;
      end else if (beat_v && idx_v == TOTAL) begin
        m_active <= 1'b0; m_done <= 1'b1; m_idx <= 0; m_sum <= m_sum + pix_data;
      end else if (start && !m_active && !m_done) begin
        m_active <= 1'b1; m_idx <= 0; m_sum <= 0;
      end else begin
        m_idx <= idx_v;
        if (beat_v) m_sum <= m_sum + pix_data;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    done_cnt = 0; tb_wr = 0; sw_wr = 0; tb63_cyc = -100; sw0_cyc = -1;
    last_sw_addr = -1; first_sw_data = 8'd0; last_sw_data = 8'd0; sum_at_done = -1;
  endtask

  task automatic compare_loop();
    bit ok;
    longint cs;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        cs = 0;
`ifdef ME_MEM_LOADER_CHECKSUM_EN
        cs = longint'(checksum);
`endif
        ok = (pix_ready == m_active) && (busy == m_active) && (done == m_done) &&
             (tb_we == m_tb_we) && (sw_we == m_sw_we) &&
             (!m_tb_we || (tb_waddr == m_tb_addr && tb_wdata == m_tb_data)) &&
             (!m_sw_we || (sw_waddr == m_sw_addr && sw_wdata == m_sw_data));
`ifdef ME_MEM_LOADER_CHECKSUM_EN
        ok = ok && (cs == m_sum);
`endif
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL cycle_%0d: got rdy=%b busy=%b done=%b tbwe=%b tba=%0d tbd=%0d swwe=%b swa=%0d swd=%0d cs=%0d want rdy=%b busy=%b done=%b tbwe=%b tba=%0d tbd=%0d swwe=%b swa=%0d swd=%0d cs=%0d",
                   cyc, pix_ready, busy, done, tb_we, tb_waddr, tb_wdata, sw_we, sw_waddr, sw_wdata, cs,
                   m_active, m_active, m_done, m_tb_we, m_tb_addr, m_tb_data, m_sw_we, m_sw_addr, m_sw_data, m_sum);
        end
        if (done) begin
          done_cnt++;
          sum_at_done = cs;
        end
        if (tb_we) begin
          tb_wr++;
          if (tb_waddr == 6'd63) tb63_cyc = cyc;
        end
        if (sw_we) begin
          sw_wr++;
          last_sw_addr = int'(sw_waddr);
          if (sw_waddr == 10'd0) begin sw0_cyc = cyc; first_sw_data = sw_wdata; end
          if (sw_waddr == 10'd1023) last_sw_data = sw_wdata;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: valid always; mode 1: valid pattern 1,0,0,1 repeating.
  task automatic stream(input int n, input int mode, input int abort_at, input int start_at,
                        input bit all_ff, output int sent);
    int c;
    bit acc;
    c = 0;
    sent = 0;
    while (sent < n && c < 6000) begin
      pix_valid = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      pix_data  = all_ff ? 8'hFF : 8'(sent);
      abort     = (abort_at >= 0) && (sent == abort_at) && pix_valid;
      start     = (start_at >= 0) && (sent == start_at);
      acc       = pix_valid && pix_ready;
      tick();
      c++;
      start = 1'b0;
      if (acc) sent++;
      if (abort) break;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
  endtask

  initial begin
    int sent;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_data = 8'd0;
    clear_stats();
    fork
      compare_loop();
    join_none
    chk_on = 1'b1;
    repeat (3) tick();
    check("reset_tb_we", tb_we, 0);
    check("reset_sw_we", sw_we, 0);
    check("reset_ready", pix_ready, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Continuous stream.
    clear_stats();
    do_start();
    stream(TOTAL, 0, -1, -1, 1'b0, sent);
    repeat (4) tick();
    check("cont_sent", sent, TOTAL);
    check("cont_done_cnt", done_cnt, 1);
    check("cont_tb_writes", tb_wr, 64);
    check("cont_sw_writes", sw_wr, 1024);
    check("cont_first_sw_data", first_sw_data, 64);
    check("cont_last_sw_data", last_sw_data, 63);
    check("cont_tb_sw_boundary", sw0_cyc - tb63_cyc, 1);

    // Throttled stream.
    clear_stats();
    do_start();
    stream(TOTAL, 1, -1, -1, 1'b0, sent);
    repeat (4) tick();
    check("thr_done_cnt", done_cnt, 1);
    check("thr_tb_writes", tb_wr, 64);
    check("thr_sw_writes", sw_wr, 1024);
    check("thr_last_sw_data", last_sw_data, 63);

    // Abort at SW count 500; the coincident beat is still written.
    clear_stats();
    do_start();
    stream(TOTAL, 0, TB_N + 500, -1, 1'b0, sent);
    repeat (4) tick();
    check("abort_sent", sent, TB_N + 501);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_sw_writes", sw_wr, 501);
    check("abort_last_sw_addr", last_sw_addr, 500);
    check("abort_ready", pix_ready, 0);
    clear_stats();
    do_start();
    stream(TOTAL, 0, -1, -1, 1'b0, sent);
    repeat (4) tick();
    check("reload_done_cnt", done_cnt, 1);
    check("reload_tb_writes", tb_wr, 64);

    // Start ignored while busy.
    clear_stats();
    do_start();
    stream(TOTAL, 0, -1, 10, 1'b0, sent);
    repeat (4) tick();
    check("busystart_done_cnt", done_cnt, 1);
    check("busystart_sw_writes", sw_wr, 1024);

    // Abort and start together in IDLE: stays idle.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);

    // Reset mid-load with a coincident beat: no write follows.
    clear_stats();
    do_start();
    stream(30, 0, -1, -1, 1'b0, sent);
    pix_valid = 1'b1; rst = 1'b1;
    tick();
    pix_valid = 1'b0; rst = 1'b0;
    check("rst_flush_tb_we", tb_we, 0);
    check("rst_tb_writes", tb_wr, 30);
    check("rst_busy", busy, 0);

`ifdef ME_MEM_LOADER_CHECKSUM_EN
    clear_stats();
    do_start();
    stream(TOTAL, 0, -1, -1, 1'b1, sent);
    repeat (4) tick();
    check("checksum_at_done", sum_at_done, 277440);
`endif

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/me_mem_loader.md
Name: me_mem_loader

Overview:
- Write-side counterpart of the search-memory address generator. Accepts a raster pixel stream with a valid/ready handshake.
- Fills the template-block memory first: 8x8, 64 words. Then fills the search-window memory: 32x32, 1024 words.
- Generates write addresses, write enables and write data for both memories.
- Pulses done so the matching engine can start reading.

Parameters:
- PIX_W, 8, pixel data width
- TB_AW, 6, template memory address width (depth 2**TB_AW)
- SW_AW, 10, search-window memory address width (depth 2**SW_AW)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a load; sampled only in IDLE
- abort  in  1  synchronous abort back to IDLE
- pix_valid  in  1  input pixel valid
- pix_data  in  PIX_W  input pixel
- pix_ready  out  1  loader accepts a pixel this cycle
- tb_we  out  1  template memory write enable
- tb_waddr  out  TB_AW  template write address
- tb_wdata  out  PIX_W  template write data
- sw_we  out  1  search-window memory write enable
- sw_waddr  out  SW_AW  search-window write address
- sw_wdata  out  PIX_W  search-window write data
- busy  out  1  high in LOAD_TB or LOAD_SW
- done  out  1  one-cycle pulse when the load completes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, both address counters 0.
- States: IDLE, LOAD_TB, LOAD_SW, DONE.
- IDLE: start=1 -> LOAD_TB; both counters cleared.
- Ready and beats:
  - pix_ready is combinational: 1 iff state is LOAD_TB or LOAD_SW.
  - A beat is pix_valid & pix_ready.
  - pix_valid is ignored when ready=0.
- Write latency:
  - Exactly 1 cycle.
  - A beat accepted in cycle N produces a registered write (we=1, addr=counter value at N, wdata=pix_data at N) in cycle N+1.
  - we=0 in every cycle without a preceding beat.
- LOAD_TB:
  - Each beat increments the TB counter.
  - The beat at TB count 2**TB_AW-1 moves to LOAD_SW; the TB counter wraps to 0.
  - The next cycle's beat goes to SW address 0 with no bubble.
- LOAD_SW:
  - Each beat increments the SW counter.
  - The beat at SW count 2**SW_AW-1 moves to DONE.
- DONE:
  - Lasts one cycle; done=1 in the same cycle as the final sw_we (addr 2**SW_AW-1).
  - Then unconditionally returns to IDLE.
- Counters: modulo 2**AW. Never exceed depth. No other wrap is reachable.
- start while busy or in DONE: ignored.
- abort:
  - Any non-IDLE state -> IDLE next cycle; counters cleared.
  - pix_ready drops combinationally in the abort cycle only if abort is qualified. Specification: a beat coincident with abort is still accepted and written in the following cycle.
  - No done pulse follows an abort.
- abort and start together in IDLE: abort wins, stays IDLE.
- rst mid-load: same as abort, and any pending write is suppressed (we=0 next cycle).
- tb_we and sw_we are never high in the same cycle.

Optional Feature:
- Macro: ME_MEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [PIX_W+SW_AW:0].
  - Checksum is a running unsigned sum of every accepted pixel (TB and SW) since the last start.
  - Cleared on start, rst and abort.
  - Final value is valid in the cycle done=1 and held until the next start.
- When undefined: no port, no adder logic.

Decomposition:
- Shared package me_pkg holds:
  - state enum loader_state_t {IDLE, LOAD_TB, LOAD_SW, DONE}
  - constants TB_DEPTH=64, SW_DEPTH=1024, PIX_W=8
- One natural sub-module: me_wr_port, a registered write stage (we/addr/data pipeline register with flush). Instantiated twice, once for TB and once for SW.

Test Plan:
- Continuous stream:
  - Stimulus: start, then 1088 beats with pix_valid held 1, data = index mod 256.
  - Required: tb_waddr 0..63 with data 0..63; sw_waddr 0..1023 with data 64..255,0..; done pulses once, aligned with sw_waddr=1023; busy falls the following cycle.
- Throttled stream:
  - Stimulus: pix_valid toggles 1,0,0,1 pattern.
  - Required: writes occur only one cycle after accepted beats; address sequence identical to the continuous case; no duplicate or skipped addresses.
- TB->SW boundary:
  - Stimulus: beats 63 and 64 on consecutive cycles.
  - Required: tb_we addr 63, then sw_we addr 0 on the next cycle; never both high together.
- Abort mid-SW:
  - Stimulus: abort at SW count 500.
  - Required: IDLE next cycle; pix_ready=0; no done; a new start reloads from tb_waddr 0.
- Start ignored while busy:
  - Stimulus: pulse start at TB count 10.
  - Required: counters unaffected; the load completes normally with a single done.
- Checksum (macro defined):
  - Stimulus: 1088 beats all 0xFF.
  - Required: checksum = 277440 when done=1.
